// File: rtl/bp_sacc_cmd_buffer_pkg.sv
// bp_sacc_cmd_buffer_pkg
// Shared types for the streaming-accelerator command buffer. It holds the
// processor-config widths, the BedRock memory message layout (header + data
// block), the buffer FSM state encoding and a safe clog2 helper.
// No ports (package).
package bp_sacc_cmd_buffer_pkg;

  // Processor configuration (default config).
  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 64;
  localparam int lce_id_width_p    = 4;
  localparam int lce_assoc_p       = 8;

  // clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  localparam int lce_way_width_lp = safe_clog2(lce_assoc_p);

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef struct packed {
    bp_bedrock_mem_type_e          msg_type;
    logic [2:0]                    size;
    logic [lce_id_width_p-1:0]     lce_id;
    logic [lce_way_width_lp-1:0]   way_id;
    logic [paddr_width_p-1:0]      addr;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    bp_bedrock_mem_header_s        header;
    logic [cce_block_width_p-1:0]  data;
  } bp_bedrock_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_bedrock_mem_msg_s);

  typedef enum logic [1:0] {
    e_sacc_idle      = 2'd0,
    e_sacc_wait_resp = 2'd1,
    e_sacc_return    = 2'd2
  } bp_sacc_cmd_buffer_state_e;

endpackage

// File: rtl/bp_sacc_cmd_buffer_fifo.sv
// bp_sacc_cmd_buffer_fifo
// Small 1-read/1-write FIFO holding the queued I/O commands. It uses
// valid/ready on the write side and valid/yumi on the read side. All control
// state resets asynchronously (active low); the storage array does not reset.
// Ports:
//   clk_i, reset_n_i       clock, async active-low reset
//   data_i, v_i, ready_o   enqueue side (ready_o = not full, low in reset)
//   data_o, v_o, yumi_i    dequeue side (data_o = head, v_o = not empty)
module bp_sacc_cmd_buffer_fifo
  import bp_sacc_cmd_buffer_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = safe_clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [cnt_width_lp-1:0] cnt_r;
  logic                    full, empty, enq, deq;

  assign full    = (cnt_r == cnt_width_lp'(els_p));
  assign empty   = (cnt_r == '0);
  // Held low while reset is asserted so nothing is accepted during reset.
  assign ready_o = ~full & reset_n_i;
  assign v_o     = ~empty;
  assign data_o  = mem_r[rd_ptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & ~empty;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (enq)
        wr_ptr_r <= (wr_ptr_r == ptr_width_lp'(els_p - 1)) ? '0 : wr_ptr_r + ptr_width_lp'(1);
      if (deq)
        rd_ptr_r <= (rd_ptr_r == ptr_width_lp'(els_p - 1)) ? '0 : rd_ptr_r + ptr_width_lp'(1);
      case ({enq, deq})
        2'b10:   cnt_r <= cnt_r + cnt_width_lp'(1);
        2'b01:   cnt_r <= cnt_r - cnt_width_lp'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_sacc_cmd_buffer.sv
// bp_sacc_cmd_buffer
// Command buffer in front of a streaming accelerator's CCE-IO command port.
// It queues uncached I/O commands from the network and issues them to the
// accelerator one at a time. It captures the accelerator's one-cycle response
// pulse and holds it for the network until the network yumis it. Responses
// that arrive while no command is outstanding are drained and flagged as
// spurious.
// Optional feature: define BP_SACC_CMD_BUFFER_TIMEOUT_EN to build a response
// watchdog. On expiry it returns {issued header, all-ones data} and sets
// timeout_o. Without it, WAIT_RESP waits forever and timeout_o is 0.
// Ports:
//   clk_i, reset_n_i                      clock, async active-low reset
//   io_cmd_i/io_cmd_v_i/io_cmd_ready_o    command in from network
//   io_resp_o/io_resp_v_o/io_resp_yumi_i  held response out to network
//   acc_cmd_o/acc_cmd_v_o/acc_cmd_ready_i command out to accelerator
//   acc_resp_i/acc_resp_v_i/acc_resp_yumi_o accelerator response pulse in
//   busy_o, spurious_o, timeout_o         status (spurious/timeout sticky)
//
// state      | meaning
// IDLE       | no command outstanding; queue head offered to accelerator
// WAIT_RESP  | one command issued; waiting for its response pulse
// RETURN     | response held on io_resp_o until the network yumis it
module bp_sacc_cmd_buffer
  import bp_sacc_cmd_buffer_pkg::*;
#(
  parameter int fifo_els_p       = 4,
  parameter int timeout_cycles_p = 256
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i,
  output logic [cce_mem_msg_width_lp-1:0] acc_cmd_o,
  output logic                            acc_cmd_v_o,
  input  logic                            acc_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] acc_resp_i,
  input  logic                            acc_resp_v_i,
  output logic                            acc_resp_yumi_o,
  output logic                            busy_o,
  output logic                            spurious_o,
  output logic                            timeout_o
);

  bp_sacc_cmd_buffer_state_e       state_r;
  bp_bedrock_mem_msg_s             resp_r;
  logic                            spurious_r;
  logic [cce_mem_msg_width_lp-1:0] head;
  logic                            head_v, head_yumi;

  bp_sacc_cmd_buffer_fifo #(
    .width_p (cce_mem_msg_width_lp),
    .els_p   (fifo_els_p)
  ) cmd_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (io_cmd_i),
    .v_i       (io_cmd_v_i),
    .ready_o   (io_cmd_ready_o),
    .data_o    (head),
    .v_o       (head_v),
    .yumi_i    (head_yumi)
  );

  assign acc_cmd_o       = head;
  assign acc_cmd_v_o     = (state_r == e_sacc_idle) & head_v;
  assign head_yumi       = acc_cmd_v_o & acc_cmd_ready_i;
  // The accelerator never holds a response, so every pulse is drained.
  // The yumi is gated so it stays quiet while reset is asserted.
  assign acc_resp_yumi_o = acc_resp_v_i & reset_n_i;
  assign io_resp_v_o     = (state_r == e_sacc_return);
  assign io_resp_o       = resp_r;
  assign busy_o          = (state_r != e_sacc_idle) | head_v;
  assign spurious_o      = spurious_r;

`ifdef BP_SACC_CMD_BUFFER_TIMEOUT_EN
  localparam int wait_cnt_width_lp = safe_clog2(timeout_cycles_p);

  bp_bedrock_mem_msg_s            head_msg;
  bp_bedrock_mem_header_s         hdr_r;
  logic [wait_cnt_width_lp-1:0]   wait_cnt_r;
  logic                           timeout_r;

  assign head_msg  = head;
  assign timeout_o = timeout_r;
`else
  localparam int unused_timeout_cycles_lp = timeout_cycles_p;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_sacc_idle;
      resp_r     <= '0;
      spurious_r <= 1'b0;
`ifdef BP_SACC_CMD_BUFFER_TIMEOUT_EN
      hdr_r      <= '0;
      wait_cnt_r <= '0;
      timeout_r  <= 1'b0;
`endif
    end else begin
      if (acc_resp_v_i && (state_r != e_sacc_wait_resp))
        spurious_r <= 1'b1;

      unique case (state_r)
        e_sacc_idle: begin
          if (head_yumi) begin
            state_r    <= e_sacc_wait_resp;
`ifdef BP_SACC_CMD_BUFFER_TIMEOUT_EN
            hdr_r      <= head_msg.header;
            wait_cnt_r <= '0;
`endif
          end
        end
        e_sacc_wait_resp: begin
          // A real pulse takes priority over a coincident watchdog expiry.
          if (acc_resp_v_i) begin
            resp_r  <= acc_resp_i;
            state_r <= e_sacc_return;
          end
`ifdef BP_SACC_CMD_BUFFER_TIMEOUT_EN
          else if (wait_cnt_r == wait_cnt_width_lp'(timeout_cycles_p - 1)) begin
            resp_r.header <= hdr_r;
            resp_r.data   <= '1;
            timeout_r     <= 1'b1;
            state_r       <= e_sacc_return;
          end else begin
            wait_cnt_r <= wait_cnt_r + wait_cnt_width_lp'(1);
          end
`endif
        end
        e_sacc_return: begin
          if (io_resp_yumi_i)
            state_r <= e_sacc_idle;
        end
        default: state_r <= e_sacc_idle;
      endcase
    end
  end

endmodule

// File: doc/bp_sacc_cmd_buffer.md
# bp_sacc_cmd_buffer

Command buffer that sits directly upstream of a streaming accelerator's CCE-IO command port. It queues uncached I/O commands arriving from the network and issues them to the accelerator strictly one at a time. It captures each single-cycle accelerator response pulse and holds it for the network under a valid/yumi handshake. This gives the accelerator the single-outstanding, always-drained environment it requires.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p, hence cce_mem_msg_width_lp.
- fifo_els_p, 4: command queue depth, ≥2.
- timeout_cycles_p, 256: response watchdog limit. Used only when the watchdog is compiled in.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- io_cmd_i  in  cce_mem_msg_width_lp  command from network.
- io_cmd_v_i  in  1  command valid.
- io_cmd_ready_o  out  1  queue not full; valid→ready.
- io_resp_o  out  cce_mem_msg_width_lp  held response to network.
- io_resp_v_o  out  1  response valid.
- io_resp_yumi_i  in  1  network consumes response.
- acc_cmd_o  out  cce_mem_msg_width_lp  queue head to accelerator.
- acc_cmd_v_o  out  1  head valid, issued only in IDLE.
- acc_cmd_ready_i  in  1  accelerator accepts.
- acc_resp_i  in  cce_mem_msg_width_lp  accelerator response.
- acc_resp_v_i  in  1  one-cycle response pulse; not held.
- acc_resp_yumi_o  out  1  response taken this cycle.
- busy_o  out  1  state ≠ IDLE or queue non-empty.
- spurious_o  out  1  sticky: a response arrived outside WAIT_RESP.
- timeout_o  out  1  sticky: watchdog fired. Tied 0 when compiled out.

## Operation
- Queue is FIFO: write when io_cmd_v_i & io_cmd_ready_o; io_cmd_ready_o = ~full.
- No enqueue when full, even with a same-cycle dequeue. No empty bypass.
- FSM states: IDLE, WAIT_RESP, RETURN.
- IDLE:
  - acc_cmd_v_o = ~empty.
  - On acc_cmd_v_o & acc_cmd_ready_i: dequeue, latch head header into hdr_r, go to WAIT_RESP.
- WAIT_RESP:
  - acc_resp_yumi_o = acc_resp_v_i.
  - On pulse: latch acc_resp_i into resp_r, go to RETURN.
- RETURN:
  - io_resp_v_o = 1; io_resp_o = resp_r, stable until yumi.
  - On io_resp_yumi_i: go to IDLE.
- Outside WAIT_RESP:
  - acc_resp_yumi_o = acc_resp_v_i; response dropped, spurious_o set. Drain always.
- acc_cmd_o = queue head. It is meaningful only while acc_cmd_v_o is high.
- Sticky flags clear only on reset.

## Timing
- Reset (reset_n_i low, asynchronous):
  - State IDLE, queue empty, counters 0, flags 0.
  - io_cmd_ready_o = 0 while reset_n_i is low, 1 after release.
  - io_resp_v_o, acc_cmd_v_o, acc_resp_yumi_o, busy_o = 0.
- Reset mid-operation: the in-flight command and all queued commands are discarded. No response is returned for them.
- Enqueue at edge N → acc_cmd_v_o high in cycle N+1 if IDLE.
- Accelerator pulse in cycle M → io_resp_v_o high in cycle M+1.
- Yumi in cycle K → IDLE in K+1. The next acc_cmd_v_o may also be high in K+1.
- Best-case cadence with a 1-cycle accelerator is one command per 3 cycles.
- Response pulse in the same cycle as the WAIT_RESP watchdog expiry: the real response wins and timeout_o is not set.

## Configuration
- BP_SACC_CMD_BUFFER_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT_RESP and increments each WAIT_RESP cycle.
  - When the counter reaches timeout_cycles_p-1 with no pulse, the block synthesizes resp_r: header = hdr_r, data = all ones.
  - It then sets timeout_o and goes to RETURN.
  - Counter width is `BSG_SAFE_CLOG2(timeout_cycles_p)`.
- BP_SACC_CMD_BUFFER_TIMEOUT_EN undefined:
  - No counter; WAIT_RESP waits indefinitely.
  - timeout_o = 0.

## Structure
- bp_sacc_cmd_buffer_state_e (IDLE/WAIT_RESP/RETURN, 2 bits) lives in bp_me_pkg.
- Message structs come from `declare_bp_bedrock_mem_if`.
- Sub-module: bsg_fifo_1r1w_small, width cce_mem_msg_width_lp, els fifo_els_p, used for the queue. It is wrapped so it honours the asynchronous active-low reset.
- FSM, hdr_r, resp_r and the watchdog are in the top module.

## Test plan
- Single uc_wr to addr 0x0, data 0x1234; accelerator pulses 1 cycle after accept → io_resp_v_o 2 cycles after accept, header addr 0x0, held until yumi; busy_o=0 afterwards.
- Burst of 5 commands, fifo_els_p=4, accelerator never ready → 4 accepted, io_cmd_ready_o=0 on the 5th; acc_cmd_v_o stays high with the first command.
- Network withholds yumi 10 cycles → io_resp_o unchanged for all 10 cycles; acc_cmd_v_o=0 throughout; next command issued the cycle after yumi.
- Accelerator pulses acc_resp_v_i while IDLE → acc_resp_yumi_o=1 that cycle, spurious_o=1, no io_resp_v_o.
- Watchdog enabled, timeout_cycles_p=16, no response → io_resp_v_o after 16 WAIT_RESP cycles, data all ones, timeout_o=1. Pulse coinciding with expiry → real data returned, timeout_o=0.
- Drop reset_n_i while in WAIT_RESP with 2 commands queued → all outputs at reset values immediately; after release queue empty, io_cmd_ready_o=1.
